// File: rtl/qr_pkg.sv
// qr_pkg: shared definitions for the QR engine front end and core.
//   WORD_W        input word width (complex sample: imag in upper half, real in lower half)
//   N_ANT         matrix dimension
//   N_INST        channel instances per frame
//   WPI           words per instance (N_ANT*N_ANT H words followed by N_ANT y words)
//   CNT_W, IDX_W  widths of the word-slot counter and the instance index
//   RE_/IM_ bits  bit positions of the real and imaginary fields inside a word
package qr_pkg;

  localparam int WORD_W = 48;
  localparam int N_ANT  = 4;
  localparam int N_INST = 10;
  localparam int WPI    = N_ANT * N_ANT + N_ANT;

  localparam int CNT_W  = $clog2(WPI);
  localparam int IDX_W  = 4;

  localparam int RE_LSB = 0;
  localparam int RE_MSB = WORD_W / 2 - 1;
  localparam int IM_LSB = WORD_W / 2;
  localparam int IM_MSB = WORD_W - 1;

  // True for the final instance of a frame.
  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(N_INST - 1);
  endfunction

endpackage

// File: rtl/qr_ib_bank.sv
// qr_ib_bank: one instance-sized register bank of the input ping-pong buffer.
//   i_clk, i_rst_n  clock, asynchronous active-low reset (clears all words and the tag)
//   i_we, i_waddr   write one word into slot i_waddr
//   i_wdata         word to store
//   i_tag_we, i_tag latch the instance index for the data held in this bank
//   o_h             H flattened, element (r,c) at slice c*N_ANT+r
//   o_y             y flattened, element r at slice r
//   o_tag           instance index latched with the data
module qr_ib_bank
  import qr_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_we,
  input  logic [CNT_W-1:0]                i_waddr,
  input  logic [WORD_W-1:0]               i_wdata,
  input  logic                            i_tag_we,
  input  logic [IDX_W-1:0]                i_tag,
  output logic [N_ANT*N_ANT*WORD_W-1:0]   o_h,
  output logic [N_ANT*WORD_W-1:0]         o_y,
  output logic [IDX_W-1:0]                o_tag
);

  logic [WORD_W-1:0] mem [WPI];
  logic [IDX_W-1:0]  tag_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < WPI; k++) mem[k] <= '0;
      tag_q <= '0;
    end else begin
      for (int k = 0; k < WPI; k++) begin
        if (i_we && (i_waddr == CNT_W'(k))) mem[k] <= i_wdata;
      end
      if (i_tag_we) tag_q <= i_tag;
    end
  end

  // H arrives column-major (word k is row k%N_ANT, col k/N_ANT), which is
  // exactly the output slice order, so word k maps straight to slice k.
  for (genvar k = 0; k < N_ANT * N_ANT; k++) begin : g_h
    assign o_h[k*WORD_W +: WORD_W] = mem[k];
  end

  for (genvar r = 0; r < N_ANT; r++) begin : g_y
    assign o_y[r*WORD_W +: WORD_W] = mem[N_ANT*N_ANT + r];
  end

  assign o_tag = tag_q;

endmodule

// File: rtl/qr_input_buffer.sv
// qr_input_buffer: assembles the i_trig/i_data word stream into complete channel
// instances (H then y) in a two-bank ping-pong buffer and presents each instance
// in parallel to the QR engine, tagged with its index in the frame.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_trig, i_data  input word strobe and word (no backpressure on this side)
//   o_vld, i_rdy    output handshake
//   o_h, o_y        instance contents from the bank being read
//   o_idx, o_last   instance index within the frame, final-instance marker
//   o_overflow      sticky: a word arrived while the bank it targets was still full
//
// Handshake: o_vld is high exactly while the read bank holds a complete instance;
// a transfer happens on a rising edge where o_vld and i_rdy are both high.
// o_h/o_y/o_idx/o_last are held stable while o_vld=1 and i_rdy=0, and i_rdy has
// no effect while o_vld=0.
module qr_input_buffer
  import qr_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_trig,
  input  logic [WORD_W-1:0]               i_data,
  output logic                            o_vld,
  input  logic                            i_rdy,
  output logic [N_ANT*N_ANT*WORD_W-1:0]   o_h,
  output logic [N_ANT*WORD_W-1:0]         o_y,
  output logic [IDX_W-1:0]                o_idx,
  output logic                            o_last,
  output logic                            o_overflow
);

  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] wr_cnt;
  logic [IDX_W-1:0] inst_cnt;
  logic             overflow_q;

  logic             wr_ok;
  logic             wr_done;
  logic             xfer;

  logic [N_ANT*N_ANT*WORD_W-1:0] h0, h1;
  logic [N_ANT*WORD_W-1:0]       y0, y1;
  logic [IDX_W-1:0]              tag0, tag1;

  // Both sides look at the registered full flags, so a bank freed by a transfer
  // only becomes writable on the following cycle.
  assign wr_ok   = i_trig && !full[wr_bank];
  assign wr_done = wr_ok && (wr_cnt == CNT_W'(WPI - 1));
  assign xfer    = full[rd_bank] && i_rdy;

  // A completing bank is empty and a transferring bank is full, so the set and
  // the clear can never hit the same bank.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (xfer)    full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      inst_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_ok) begin
        if (wr_done) begin
          wr_cnt   <= '0;
          wr_bank  <= ~wr_bank;
          inst_cnt <= is_last_idx(inst_cnt) ? '0 : inst_cnt + 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (i_trig && full[wr_bank]) overflow_q <= 1'b1;
      if (xfer) rd_bank <= ~rd_bank;
    end
  end

  qr_ib_bank u_bank0 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (wr_ok && !wr_bank),
    .i_waddr  (wr_cnt),
    .i_wdata  (i_data),
    .i_tag_we (wr_done && !wr_bank),
    .i_tag    (inst_cnt),
    .o_h      (h0),
    .o_y      (y0),
    .o_tag    (tag0)
  );

  qr_ib_bank u_bank1 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (wr_ok && wr_bank),
    .i_waddr  (wr_cnt),
    .i_wdata  (i_data),
    .i_tag_we (wr_done && wr_bank),
    .i_tag    (inst_cnt),
    .o_h      (h1),
    .o_y      (y1),
    .o_tag    (tag1)
  );

  always_comb begin
    o_vld  = full[rd_bank];
    o_h    = rd_bank ? h1 : h0;
    o_y    = rd_bank ? y1 : y0;
    o_idx  = rd_bank ? tag1 : tag0;
    o_last = is_last_idx(o_idx);
  end

  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_qr_input_buffer.sv
// tb_qr_input_buffer: directed and randomised stimulus for qr_input_buffer with a
// scoreboard; expected instances are queued as words are issued and a monitor
// pops and compares them on every output transfer.
module tb_qr_input_buffer;
  import qr_pkg::*;

  localparam int H_W   = N_ANT * N_ANT * WORD_W;
  localparam int Y_W   = N_ANT * WORD_W;
  localparam int EXP_W = H_W + Y_W + IDX_W + 1;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_trig;
  logic [WORD_W-1:0] i_data;
  logic              o_vld;
  logic              i_rdy;
  logic [H_W-1:0]    o_h;
  logic [Y_W-1:0]    o_y;
  logic [IDX_W-1:0]  o_idx;
  logic              o_last;
  logic              o_overflow;

  qr_input_buffer dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_trig     (i_trig),
    .i_data     (i_data),
    .o_vld      (o_vld),
    .i_rdy      (i_rdy),
    .o_h        (o_h),
    .o_y        (o_y),
    .o_idx      (o_idx),
    .o_last     (o_last),
    .o_overflow (o_overflow)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int n_xfer = 0;

  logic [EXP_W-1:0]  exp_q[$];
  logic [WORD_W-1:0] acc [WPI];
  int                acc_cnt = 0;
  logic [IDX_W-1:0]  mdl_idx = '0;
  logic [EXP_W-1:0]  mon_e;

  task automatic chk(input string name, input logic [H_W-1:0] got, input logic [H_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [WORD_W-1:0] mk_word(input int im, input int re);
    logic [WORD_W-1:0] w;
    w = '0;
    w[IM_MSB:IM_LSB] = 24'(im);
    w[RE_MSB:RE_LSB] = 24'(re);
    return w;
  endfunction

  function automatic logic [H_W-1:0] exp_h(input logic [EXP_W-1:0] e);
    return e[IDX_W+1+Y_W +: H_W];
  endfunction

  function automatic logic [Y_W-1:0] exp_y(input logic [EXP_W-1:0] e);
    return e[IDX_W+1 +: Y_W];
  endfunction

  // Reference model: collect WPI words, place H by (row, col) of each word and
  // queue the expected instance together with its frame index.
  task automatic model_push(input logic [WORD_W-1:0] w);
    logic [H_W-1:0] h;
    logic [Y_W-1:0] y;
    int r, c;
    acc[acc_cnt] = w;
    acc_cnt++;
    if (acc_cnt == WPI) begin
      h = '0;
      y = '0;
      for (int k = 0; k < N_ANT * N_ANT; k++) begin
        r = k % N_ANT;
        c = k / N_ANT;
        h[(c*N_ANT + r)*WORD_W +: WORD_W] = acc[k];
      end
      for (int k = 0; k < N_ANT; k++) y[k*WORD_W +: WORD_W] = acc[N_ANT*N_ANT + k];
      exp_q.push_back({h, y, mdl_idx, (mdl_idx == IDX_W'(N_INST - 1))});
      mdl_idx = (mdl_idx == IDX_W'(N_INST - 1)) ? '0 : mdl_idx + 1'b1;
      acc_cnt = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [WORD_W-1:0] w, input bit accept);
    i_trig = 1'b1;
    i_data = w;
    if (accept) model_push(w);
    @(posedge i_clk); #1;
    i_trig = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_trig  = 1'b0;
    acc_cnt = 0;
    mdl_idx = '0;
    exp_q.delete();
    #2;
    chk("rst_vld",  H_W'(o_vld), '0);
    chk("rst_ovf",  H_W'(o_overflow), '0);
    chk("rst_idx",  H_W'(o_idx), '0);
    chk("rst_last", H_W'(o_last), '0);
    chk("rst_h",    o_h, '0);
    chk("rst_y",    H_W'(o_y), '0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge i_clk); #1;
      i++;
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending instances expected 0", exp_q.size());
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && o_vld === 1'b1 && i_rdy === 1'b1) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_xfer: got idx %0d expected no transfer", o_idx);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer_h",    o_h, exp_h(mon_e));
        chk("xfer_y",    H_W'(o_y), H_W'(exp_y(mon_e)));
        chk("xfer_idx",  H_W'(o_idx), H_W'(mon_e[IDX_W:1]));
        chk("xfer_last", H_W'(o_last), H_W'(mon_e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  int x0;

  initial begin
    i_rst_n = 1'b0;
    i_trig  = 1'b0;
    i_data  = '0;
    i_rdy   = 1'b0;
    do_reset();

    // 1: single instance
    i_rdy = 1'b1;
    for (int k = 0; k < WPI - 1; k++) send_word(mk_word(k + 100, k), 1'b1);
    chk("t1_vld_before", H_W'(o_vld), '0);
    send_word(mk_word(WPI - 1 + 100, WPI - 1), 1'b1);
    chk("t1_vld",  H_W'(o_vld), H_W'(1));
    chk("t1_h10",  H_W'(o_h[1*WORD_W +: WORD_W]), H_W'(mk_word(101, 1)));
    chk("t1_y3",   H_W'(o_y[3*WORD_W +: WORD_W]), H_W'(mk_word(119, 19)));
    chk("t1_idx",  H_W'(o_idx), '0);
    chk("t1_last", H_W'(o_last), '0);
    idle(1);
    chk("t1_vld_drop", H_W'(o_vld), '0);
    wait_drain(10);

    // 2: full frame plus first instance of the next frame
    do_reset();
    i_rdy = 1'b1;
    x0 = n_xfer;
    for (int k = 0; k < (N_INST + 1) * WPI; k++) send_word(mk_word(2000 + k, k), 1'b1);
    wait_drain(50);
    chk("t2_xfers", H_W'(n_xfer - x0), H_W'(N_INST + 1));
    chk("t2_ovf",   H_W'(o_overflow), '0);

    // 3: backpressure, both banks full, then an overflowing word
    do_reset();
    i_rdy = 1'b0;
    for (int k = 0; k < 2 * WPI; k++) send_word(mk_word(3000 + k, k), 1'b1);
    chk("t3_vld", H_W'(o_vld), H_W'(1));
    chk("t3_idx", H_W'(o_idx), '0);
    chk("t3_h_a", o_h, exp_h(exp_q[0]));
    idle(5);
    chk("t3_h_stable", o_h, exp_h(exp_q[0]));
    chk("t3_ovf_before", H_W'(o_overflow), '0);
    send_word(mk_word(3999, 999), 1'b0);
    chk("t3_ovf", H_W'(o_overflow), H_W'(1));
    chk("t3_h_after_drop", o_h, exp_h(exp_q[0]));
    i_rdy = 1'b1;
    idle(1);
    i_rdy = 1'b0;
    chk("t3_vld_next", H_W'(o_vld), H_W'(1));
    chk("t3_idx_next", H_W'(o_idx), H_W'(1));
    i_rdy = 1'b1;
    wait_drain(10);
    chk("t3_ovf_sticky", H_W'(o_overflow), H_W'(1));

    // 4: completion into one bank in the same cycle the other bank transfers
    do_reset();
    i_rdy = 1'b0;
    for (int k = 0; k < WPI; k++) send_word(mk_word(4000 + k, k), 1'b1);
    for (int k = 0; k < WPI - 1; k++) send_word(mk_word(4100 + k, k), 1'b1);
    i_rdy = 1'b1;
    send_word(mk_word(4100 + WPI - 1, WPI - 1), 1'b1);
    chk("t4_vld", H_W'(o_vld), H_W'(1));
    chk("t4_idx", H_W'(o_idx), H_W'(1));
    wait_drain(10);

    // 5: reset in the middle of an instance
    i_rdy = 1'b1;
    for (int k = 0; k < 7; k++) send_word(mk_word(5000 + k, k), 1'b1);
    do_reset();
    x0 = n_xfer;
    for (int k = 0; k < WPI; k++) send_word(mk_word(5100 + k, 50 + k), 1'b1);
    wait_drain(10);
    chk("t5_xfers", H_W'(n_xfer - x0), H_W'(1));

    // 6: random input gaps and random consumer readiness over three frames
    do_reset();
    x0 = n_xfer;
    for (int k = 0; k < 3 * N_INST * WPI; k++) begin
      repeat ($urandom_range(0, 2)) begin
        i_rdy = 1'($urandom_range(0, 1));
        idle(1);
      end
      i_rdy = 1'($urandom_range(0, 1));
      send_word(mk_word(int'($urandom_range(0, 24'hffffff)), int'($urandom_range(0, 24'hffffff))), 1'b1);
    end
    i_rdy = 1'b1;
    wait_drain(100);
    chk("t6_xfers", H_W'(n_xfer - x0), H_W'(3 * N_INST));
    chk("t6_ovf",   H_W'(o_overflow), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "simulation time limit reached");
  end

endmodule
